line_follow_sequencer: RTL and testbench

LINE_FOLLOW_SEQUENCER -- requirements
Module: line_follow_sequencer

---
 rtl/line_follow_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_line_follow_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/line_follow_sequencer.sv
// Line-following robot sequencer: synchronised, debounced L/M/R sensors drive a
// drive/search/fault FSM with motor enables. Define LFS_PWM_EN to generate PWM enables.
module line_follow_sequencer #(
    parameter int DEBOUNCE       = 4,
    parameter int LOST_TIMEOUT   = 32,
    parameter int BACKUP_CYCLES  = 8,
    parameter int SEARCH_TIMEOUT = 256,
    parameter int PWM_PERIOD     = 16,
    parameter int DUTY_FWD       = 12,
    parameter int DUTY_TURN      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       L,
    input  logic       M,
    input  logic       R,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] state,
    output logic       ENA,
    output logic       ENB,
    output logic       fault,
    output logic       busy
);

    localparam int DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int LW       = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT + 1) : 1;
    localparam int SRCH_MAX = (SEARCH_TIMEOUT > BACKUP_CYCLES) ? SEARCH_TIMEOUT : BACKUP_CYCLES;
    localparam int SW       = (SRCH_MAX > 1) ? $clog2(SRCH_MAX + 1) : 1;

    localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_TIMEOUT - 1);
    localparam logic [SW-1:0] BACKUP_LAST = SW'(BACKUP_CYCLES - 1);
    localparam logic [SW-1:0] SRCH_LAST   = SW'(SEARCH_TIMEOUT - 1);

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_LEFT, S_RIGHT, S_BACKUP, S_PIVOT, S_FAULT
    } fsm_t;

    typedef enum logic [2:0] {
        D_FWD, D_LEFT, D_RIGHT, D_HOLD, D_LOST
    } dec_t;

    function automatic dec_t decode(input logic [2:0] p);
        case (p)
            3'b010, 3'b111: decode = D_FWD;
            3'b110, 3'b100: decode = D_LEFT;
            3'b011, 3'b001: decode = D_RIGHT;
            3'b101:         decode = D_HOLD;
            default:        decode = D_LOST;
        endcase
    endfunction

    function automatic logic [2:0] drive_code(input fsm_t s, input logic dir);
        case (s)
            S_FWD:    drive_code = 3'd1;
            S_LEFT:   drive_code = 3'd2;
            S_RIGHT:  drive_code = 3'd3;
            S_BACKUP: drive_code = 3'd4;
            S_PIVOT:  drive_code = (dir == DIR_L) ? 3'd2 : 3'd3;
            default:  drive_code = 3'd0;
        endcase
    endfunction

    // ---------------- sensor synchroniser and debounce ----------------
    logic [2:0]    sync1_reg, sync2_reg, cand_reg, acc_reg;
    logic [DW-1:0] db_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            cand_reg   <= '0;
            acc_reg    <= '0;
            db_cnt_reg <= '0;
        end else begin
            sync1_reg <= {L, M, R};
            sync2_reg <= sync1_reg;
            if (sync2_reg != cand_reg) begin
                // first cycle of a new value counts as stable cycle one
                cand_reg   <= sync2_reg;
                db_cnt_reg <= DW'(1);
                if (DEBOUNCE <= 1) acc_reg <= sync2_reg;
            end else if (db_cnt_reg < DB_MAX) begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
                if (db_cnt_reg == DB_LAST) acc_reg <= cand_reg;
            end
        end
    end

    // ---------------- sequencing FSM ----------------
    fsm_t          st_reg, st_next;
    logic          dir_reg, dir_next;
    logic [LW-1:0] lost_reg, lost_next;
    logic [SW-1:0] srch_reg, srch_next;
    logic          fault_next;
    logic          busy_next;
    dec_t          dec;

    always_comb begin
        st_next    = st_reg;
        dir_next   = dir_reg;
        lost_next  = lost_reg;
        srch_next  = srch_reg;
        fault_next = fault;
        dec        = decode(acc_reg);

        if (stop) begin
            st_next   = S_IDLE;
            lost_next = '0;
            srch_next = '0;
        end else begin
            case (st_reg)
                S_IDLE, S_FAULT: begin
                    if (start) begin
                        fault_next = 1'b0;
                        lost_next  = '0;
                        srch_next  = '0;
                        case (dec)
                            D_LEFT:  begin st_next = S_LEFT;  dir_next = DIR_L; end
                            D_RIGHT: begin st_next = S_RIGHT; dir_next = DIR_R; end
                            default: st_next = S_FWD;
                        endcase
                    end
                end
                S_FWD, S_LEFT, S_RIGHT: begin
                    case (dec)
                        D_FWD:   begin st_next = S_FWD; lost_next = '0; end
                        D_LEFT:  begin st_next = S_LEFT;  dir_next = DIR_L; lost_next = '0; end
                        D_RIGHT: begin st_next = S_RIGHT; dir_next = DIR_R; lost_next = '0; end
                        D_HOLD:  lost_next = '0;
                        default: begin
                            if (lost_reg >= LOST_LAST) begin
                                st_next   = S_BACKUP;
                                lost_next = '0;
                                srch_next = '0;
                            end else begin
                                lost_next = lost_reg + 1'b1;
                            end
                        end
                    endcase
                end
                S_BACKUP, S_PIVOT: begin
                    case (dec)
                        D_FWD:   begin st_next = S_FWD; lost_next = '0; srch_next = '0; end
                        D_LEFT:  begin st_next = S_LEFT;  dir_next = DIR_L; lost_next = '0; srch_next = '0; end
                        D_RIGHT: begin st_next = S_RIGHT; dir_next = DIR_R; lost_next = '0; srch_next = '0; end
                        default: begin
                            // 101 carries no direction, so the search keeps running
                            if (srch_reg >= SRCH_LAST) begin
                                st_next    = S_FAULT;
                                fault_next = 1'b1;
                                srch_next  = '0;
                                lost_next  = '0;
                            end else begin
                                srch_next = srch_reg + 1'b1;
                                if (st_reg == S_BACKUP && srch_reg >= BACKUP_LAST)
                                    st_next = S_PIVOT;
                            end
                        end
                    endcase
                end
                default: begin
                    st_next   = S_IDLE;
                    lost_next = '0;
                    srch_next = '0;
                end
            endcase
        end

        busy_next = (st_next != S_IDLE) && (st_next != S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg   <= S_IDLE;
            dir_reg  <= DIR_L;
            lost_reg <= '0;
            srch_reg <= '0;
            state    <= 3'd0;
            fault    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            st_reg   <= st_next;
            dir_reg  <= dir_next;
            lost_reg <= lost_next;
            srch_reg <= srch_next;
            state    <= drive_code(st_next, dir_next);
            fault    <= fault_next;
            busy     <= busy_next;
        end
    end

    // ---------------- motor enables ----------------
`ifdef LFS_PWM_EN
    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

    logic [PW-1:0] pwm_reg, pwm_next;
    logic [31:0]   duty_next;

    always_comb begin
        pwm_next = (pwm_reg >= PWM_LAST) ? '0 : pwm_reg + 1'b1;
        case (st_next)
            S_FWD:                               duty_next = 32'(DUTY_FWD);
            S_LEFT, S_RIGHT, S_BACKUP, S_PIVOT:  duty_next = 32'(DUTY_TURN);
            default:                             duty_next = 32'd0;
        endcase
    end

    // enable registered against the counter value it will sit beside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= '0;
            ENA     <= 1'b0;
            ENB     <= 1'b0;
        end else begin
            pwm_reg <= pwm_next;
            ENA     <= (32'(pwm_next) < duty_next);
            ENB     <= (32'(pwm_next) < duty_next);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ENA <= 1'b0;
            ENB <= 1'b0;
        end else begin
            ENA <= busy_next;
            ENB <= busy_next;
        end
    end
`endif

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer at default parameters; expected
// cycle counts are hand-derived from sensor-to-state latency and timeouts.
module tb_line_follow_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       L, M, R, start, stop;
    logic [2:0] state;
    logic       ENA, ENB, fault, busy;

    int checks = 0;
    int errors = 0;

    line_follow_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .L     (L),
        .M     (M),
        .R     (R),
        .start (start),
        .stop  (stop),
        .state (state),
        .ENA   (ENA),
        .ENB   (ENB),
        .fault (fault),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sensors(input logic [2:0] p);
        {L, M, R} = p;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ena_cnt, enb_cnt, exp_on;
`ifdef LFS_PWM_EN
        exp_on = 12;
`else
        exp_on = 16;
`endif
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        sensors(3'b000);
        tick(3);
        check("rst_state", int'(state), 0);
        check("rst_ena", int'(ENA), 0);
        check("rst_enb", int'(ENB), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);

        // start with centred line
        sensors(3'b010);
        tick(8);
        check("idle_before_start", int'(state), 0);
        pulse_start();
        check("start_fwd_state", int'(state), 1);
        check("start_fwd_busy", int'(busy), 1);
        ena_cnt = 0;
        enb_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            ena_cnt += int'(ENA);
            enb_cnt += int'(ENB);
        end
        check("fwd_ena_on_of_16", ena_cnt, exp_on);
        check("fwd_enb_on_of_16", enb_cnt, exp_on);

        // 010 -> 100: LEFT exactly 7 cycles later
        sensors(3'b100);
        tick(6);
        check("left_at_6", int'(state), 1);
        tick(1);
        check("left_at_7", int'(state), 2);
        sensors(3'b001);
        tick(1);
        sensors(3'b100);
        tick(12);
        check("glitch_ignored", int'(state), 2);

        // into RIGHT, then lose the line
        sensors(3'b001);
        tick(7);
        check("right_at_7", int'(state), 3);
        sensors(3'b000);
        tick(37);
        check("lost_at_37", int'(state), 3);
        tick(1);
        check("backup_at_38", int'(state), 4);
        tick(7);
        check("backup_hold_7", int'(state), 4);
        tick(1);
        check("pivot_right", int'(state), 3);
        sensors(3'b010);
        tick(6);
        check("reacq_at_6", int'(state), 3);
        tick(1);
        check("reacq_fwd_at_7", int'(state), 1);

        // search timeout into FAULT
        pulse_stop();
        check("stop_idle", int'(state), 0);
        sensors(3'b000);
        tick(8);
        pulse_start();
        check("start_lost_fwd", int'(state), 1);
        tick(31);
        check("lost_fwd_31", int'(state), 1);
        tick(1);
        check("lost_backup_32", int'(state), 4);
        tick(255);
        check("search_255_state", int'(state), 3);
        check("search_255_fault", int'(fault), 0);
        tick(1);
        check("fault_flag", int'(fault), 1);
        check("fault_state", int'(state), 0);
        check("fault_ena", int'(ENA), 0);
        check("fault_enb", int'(ENB), 0);
        check("fault_busy", int'(busy), 0);
        pulse_start();
        check("restart_fault_clr", int'(fault), 0);
        check("restart_state", int'(state), 1);

        // start+stop together in IDLE
        pulse_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_state", int'(state), 0);
        check("start_stop_busy", int'(busy), 0);

        // stop during PIVOT
        pulse_start();
        tick(32);
        check("pivot_path_backup", int'(state), 4);
        tick(8);
        check("pivot_path_pivot", int'(state), 3);
        pulse_stop();
        check("stop_in_pivot", int'(state), 0);

        // asynchronous reset mid-BACKUP
        pulse_start();
        tick(34);
        check("mid_backup", int'(state), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_ena", int'(ENA), 0);
        check("arst_enb", int'(ENB), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_fault", int'(fault), 0);
        tick(2);
        rst_n = 1'b1;
        sensors(3'b010);
        tick(12);
        check("post_reset_idle", int'(state), 0);
        pulse_start();
        check("post_reset_start", int'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
